rr_reg_arbiter: RTL
===================

Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one parameterized output data register among NREQ requesters.
- Each cycle it picks at most one requesting source and loads that source's word into the shared register.
- It presents the word downstream with a valid/ready handshake.
- It is the sequencing front-end for the single-register datapath: it decides who drives the register and when.

Parameters:
- LOG_WIDTH, 3, log2 of base width. Data width is DW = 2**LOG_WIDTH+1, which is 9 by default.
- LOG_NREQ, 2, log2 of requester count. NREQ = 2**LOG_NREQ, which is 4 by default.
- Derived localparam WIDTH = 2**LOG_WIDTH-1, which is 7.
- Derived localparam RESET_VAL = WIDTH*2+1, which is 15.
- Derived localparams are computed from parameters only and are never overridable.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-source request; bit i belongs to source i.
- req_data  input  NREQ*DW  flattened source words; source i occupies bits [i*DW +: DW].
- gnt  output  NREQ  one-hot acceptance, combinational; all zero when nothing is accepted.
- out_data  output  DW  registered shared data word.
- out_src  output  LOG_NREQ  registered index of the source that produced out_data.
- out_valid  output  1  registered; out_data/out_src are valid.
- out_ready  input  1  downstream consumer accepts the word.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - out_data = RESET_VAL
  - out_src = 0
  - out_valid = 0
  - internal last-winner pointer = NREQ-1, so source 0 has top priority after reset.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Capture is allowed when the state is EMPTY, or when the state is FULL and out_ready=1 (drain and refill in the same cycle).
- Selection, when capture is allowed and |req:
  - Winner is the first asserted req bit searching upward from (pointer+1) mod NREQ, wrapping through NREQ-1 to 0.
  - gnt[winner]=1 in that same cycle.
  - On the next edge: out_data <= req_data[winner], out_src <= winner, pointer <= winner, out_valid <= 1.
- gnt timing:
  - gnt is combinational from req, pointer, state and out_ready. There is no path from gnt back into req.
  - gnt is never asserted while capture is not allowed.
- Requester contract:
  - Hold req and req_data stable until gnt is seen.
  - Deassert req (or present the next word) in the cycle after gnt.
- Latency: 1 cycle from gnt to out_valid with the captured word.
- Sustained throughput: 1 word/cycle while out_ready=1 and some req is asserted.
- Transitions:
  - FULL with out_ready=1 and no req: go to EMPTY. out_valid=0 next cycle; out_data and out_src hold their last values.
  - FULL with out_ready=0: hold all registers, gnt=0, and leave the pointer unchanged.
  - EMPTY with no req: no change.
- Fairness: with all req bits held high, grants rotate 0,1,2,3,0,… Worst-case wait is NREQ-1 grants.
- Pointer wrap: after winner NREQ-1, the next search starts at 0.
- Reset mid-operation: out_valid drops immediately (asynchronously), any held word is discarded, gnt goes to 0, and the pointer returns to NREQ-1.
- A pending, unaccepted word is never overwritten. out_data changes only on a capture or on reset.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index wins. The pointer register is not implemented, and the reset and update rules for the pointer do not apply. All other behaviour is unchanged.
- Undefined (default): round-robin exactly as specified above.

Test Plan:
- Reset check: assert reset=0 with clock running. Required: out_data=0x00F, out_valid=0, out_src=0, gnt=0.
- Release reset, req=4'b0001, word0=9'h1A5. Required: gnt=0001 in that cycle; next cycle out_valid=1, out_data=9'h1A5, out_src=0.
- All four req high with words 9'h010..9'h013, out_ready=1 constantly. Required: gnt sequence 0001,0010,0100,1000,0001 and out_data sequence 010,011,012,013,010 on consecutive cycles.
- Backpressure: hold FULL with out_ready=0 for 3 cycles while req=4'b0110. Required: gnt=0 and out_data stable. Raise out_ready: gnt selects the next index after the pointer, and the word is replaced next cycle with no bubble.
- Pointer wrap: last winner 3, then req=4'b1001. Required: source 0 granted, not 3.
- Assert reset=0 mid-burst while FULL. Required: out_valid falls immediately. After release with req=4'b1111, source 0 is granted first. Under ARB_FIXED_PRIO_EN, source 0 wins every cycle with req=4'b1111.

Source files
------------

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that loads one shared output register and presents it with valid/ready.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no last-winner pointer).
module rr_reg_arbiter #(
  parameter  int LOG_WIDTH = 3,
  parameter  int LOG_NREQ  = 2,
  localparam int DW        = 2**LOG_WIDTH + 1,
  localparam int NREQ      = 2**LOG_NREQ
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [DW-1:0]       out_data,
  output logic [LOG_NREQ-1:0] out_src,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int WIDTH     = 2**LOG_WIDTH - 1;
  localparam int RESET_VAL = WIDTH*2 + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       data_q, data_d;
  logic [LOG_NREQ-1:0] src_q, src_d;
  logic                capture_ok;
  logic                grant_en;
  logic                found;
  logic [LOG_NREQ-1:0] win;
  logic [LOG_NREQ-1:0] idx;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = LOG_NREQ'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
`else
  logic [LOG_NREQ-1:0] ptr_q, ptr_d;

  // Search starts one past the last winner; k == NREQ wraps back onto the pointer itself.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = ptr_q + LOG_NREQ'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      ptr_d = win;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= LOG_NREQ'(NREQ-1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Gated by reset so no grant is issued while the register is being cleared.
  assign capture_ok = (state_q == EMPTY) || out_ready;
  assign grant_en   = reset && capture_ok && found;

  always_comb begin
    gnt = '0;
    if (grant_en) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    case (state_q)
      EMPTY: begin
        if (grant_en) begin
          state_d = FULL;
          data_d  = req_data[win*DW +: DW];
          src_d   = win;
        end
      end
      FULL: begin
        if (grant_en) begin
          data_d = req_data[win*DW +: DW];
          src_d  = win;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      data_q  <= DW'(RESET_VAL);
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule
